// File: rtl/logic_gate_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit between two requesters.
// Optional grant counters are enabled by defining LOGIC_ARB_STATS_EN.
module logic_gate_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] res,
    output logic             res_id,
    output logic             res_err,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [7:0]       gnt_cnt0,
    output logic [7:0]       gnt_cnt1
`endif
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             win_q, win_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             res_id_q, res_id_d;
    logic             res_err_q, res_err_d;
    logic             res_valid_q, res_valid_d;
    logic             winner;

    function automatic logic [WIDTH-1:0] gate_eval(logic [2:0] op, logic [WIDTH-1:0] a,
                                                   logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = ~(a & b);
            3'd2:    r = a | b;
            3'd3:    r = ~(a | b);
            3'd4:    r = ~a;
            3'd5:    r = a ^ b;
            3'd6:    r = ~(a ^ b);
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        win_d       = win_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        res_d       = res_q;
        res_id_d    = res_id_q;
        res_err_d   = res_err_q;
        res_valid_d = res_valid_q;
        winner      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    // On a tie the requester that did not win last time goes first.
                    winner  = (req0 && req1) ? ~last_q : req1;
                    op_d    = winner ? op1 : op0;
                    a_d     = winner ? a1 : a0;
                    b_d     = winner ? b1 : b0;
                    gnt0_d  = ~winner;
                    gnt1_d  = winner;
                    last_d  = winner;
                    win_d   = winner;
                    state_d = StExec;
                end
            end
            StExec: begin
                res_d       = gate_eval(op_q, a_q, b_q);
                res_id_d    = win_q;
                res_err_d   = (op_q == 3'd7);
                res_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            win_q       <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            res_q       <= '0;
            res_id_q    <= 1'b0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            win_q       <= win_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            res_q       <= res_d;
            res_id_q    <= res_id_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign res       = res_q;
    assign res_id    = res_id_q;
    assign res_err   = res_err_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q != StIdle);

`ifdef LOGIC_ARB_STATS_EN
    logic [7:0] cnt0_q, cnt1_q;

    // Counters saturate so a long-running consumer never sees a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= 8'd0;
            cnt1_q <= 8'd0;
        end else begin
            if (gnt0_d && (cnt0_q != 8'hFF)) cnt0_q <= cnt0_q + 8'd1;
            if (gnt1_d && (cnt1_q != 8'hFF)) cnt1_q <= cnt1_q + 8'd1;
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_logic_gate_arbiter.sv
// Self-checking bench for logic_gate_arbiter: vector table plus a result scoreboard.
module tb_logic_gate_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [2:0] op0 = '0, op1 = '0;
    logic [7:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic       gnt0, gnt1;
    logic [7:0] res;
    logic       res_id, res_err, res_valid;
    logic       res_ready = 1'b1;
    logic       busy;
`ifdef LOGIC_ARB_STATS_EN
    logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

    logic_gate_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .op0       (op0),
        .op1       (op1),
        .a0        (a0),
        .a1        (a1),
        .b0        (b0),
        .b1        (b1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .res       (res),
        .res_id    (res_id),
        .res_err   (res_err),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy)
`ifdef LOGIC_ARB_STATS_EN
        ,
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_res;
        logic       exp_err;
    } vec_t;

    typedef struct packed {
        logic [7:0] res;
        logic       id;
        logic       err;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: got res %0h id %0b with nothing expected",
                             res, res_id);
                end else begin
                    e = sb.pop_front();
                    chk("sb_res", {24'd0, res}, {24'd0, e.res});
                    chk("sb_id", {31'd0, res_id}, {31'd0, e.id});
                    chk("sb_err", {31'd0, res_err}, {31'd0, e.err});
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        op0 = '0; op1 = '0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drive_req(input logic r, input logic [2:0] op, input logic [7:0] a,
                             input logic [7:0] b);
        if (r == 1'b0) begin
            req0 = 1'b1; op0 = op; a0 = a; b0 = b;
        end else begin
            req1 = 1'b1; op1 = op; a1 = a; b1 = b;
        end
    endtask

    task automatic wait_gnt(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (gnt0 || gnt1) ok = 1'b1;
        end
        chk("grant_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) tick();
        chk("back_to_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_op(input logic r, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_res, input logic exp_err);
        logic ok;
        drive_req(r, op, a, b);
        sb.push_back('{res: exp_res, id: r, err: exp_err});
        wait_gnt(ok);
        if (ok) chk("grant_owner", {30'd0, gnt1, gnt0}, r ? 32'd2 : 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ok;
        int         ng;
        int         gid[4];
        int         gcyc[4];
        logic [7:0] av;

        vecs[0]  = '{1'b0, 3'd0, 8'hA5, 8'h0F, 8'h05, 1'b0};
        vecs[1]  = '{1'b1, 3'd1, 8'hF0, 8'hCC, 8'h3F, 1'b0};
        vecs[2]  = '{1'b0, 3'd2, 8'h50, 8'h0A, 8'h5A, 1'b0};
        vecs[3]  = '{1'b1, 3'd3, 8'h50, 8'h0A, 8'hA5, 1'b0};
        vecs[4]  = '{1'b0, 3'd4, 8'h3C, 8'hFF, 8'hC3, 1'b0};
        vecs[5]  = '{1'b1, 3'd5, 8'hFF, 8'h0F, 8'hF0, 1'b0};
        vecs[6]  = '{1'b0, 3'd6, 8'hAA, 8'h55, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, 3'd7, 8'hFF, 8'h12, 8'h00, 1'b1};
        vecs[8]  = '{1'b1, 3'd4, 8'h0F, 8'h00, 8'hF0, 1'b0};
        vecs[9]  = '{1'b0, 3'd6, 8'h12, 8'h34, 8'hD9, 1'b0};
        vecs[10] = '{1'b0, 3'd5, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[11] = '{1'b1, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0};

        fork
            monitor();
        join_none

        do_reset();
        chk("reset_outputs", {20'd0, gnt0, gnt1, res, res_id, res_err, res_valid, busy}, 32'd0);

        // Basic latency: grant one cycle after the request edge, result one cycle later.
        res_ready = 1'b1;
        drive_req(1'b0, 3'd0, 8'hF0, 8'hCC);
        sb.push_back('{res: 8'hC0, id: 1'b0, err: 1'b0});
        chk("lat_no_early_gnt", {31'd0, gnt0}, 32'd0);
        tick();
        chk("lat_gnt0_c1", {30'd0, gnt1, gnt0}, 32'd1);
        chk("lat_valid_c1", {31'd0, res_valid}, 32'd0);
        chk("lat_busy_c1", {31'd0, busy}, 32'd1);
        req0 = 1'b0;
        tick();
        chk("lat_valid_c2", {31'd0, res_valid}, 32'd1);
        chk("lat_res_c2", {24'd0, res}, 32'hC0);
        chk("lat_id_c2", {31'd0, res_id}, 32'd0);
        chk("lat_gnt_drop", {30'd0, gnt1, gnt0}, 32'd0);
        wait_idle();
        chk("res_held_after_done", {24'd0, res}, 32'hC0);

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_err);

        // Both requesters held: grants alternate 0,1,0,1 three cycles apart.
        do_reset();
        res_ready = 1'b1;
        op0 = 3'd2; a0 = 8'h01; b0 = 8'h02;
        op1 = 3'd5; a1 = 8'hFF; b1 = 8'h0F;
        for (int k = 0; k < 4; k++)
            sb.push_back('{res: (k % 2 == 0) ? 8'h03 : 8'hF0, id: 1'(k % 2), err: 1'b0});
        req0 = 1'b1;
        req1 = 1'b1;
        ng = 0;
        for (int c = 0; c < 30 && ng < 4; c++) begin
            tick();
            if (gnt0 || gnt1) begin
                gid[ng] = gnt1 ? 1 : 0;
                gcyc[ng] = c;
                if (gnt0 && gnt1) chk("rr_both_gnt", 32'd1, 32'd0);
                ng++;
                if (ng == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        chk("rr_grant_count", ng, 32'd4);
        for (int k = 0; k < ng; k++) begin
            chk("rr_order", gid[k], k % 2);
            if (k > 0) chk("rr_spacing", gcyc[k] - gcyc[k-1], 32'd3);
        end
        wait_idle();

        // Consumer stall: result held, pending requester 1 waits until after READY.
        res_ready = 1'b0;
        drive_req(1'b0, 3'd0, 8'hFF, 8'h0F);
        sb.push_back('{res: 8'h0F, id: 1'b0, err: 1'b0});
        wait_gnt(ok);
        req0 = 1'b0;
        drive_req(1'b1, 3'd2, 8'h01, 8'h02);
        sb.push_back('{res: 8'h03, id: 1'b1, err: 1'b0});
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", {31'd0, res_valid}, 32'd1);
            chk("stall_res", {24'd0, res}, 32'h0F);
            chk("stall_no_gnt1", {31'd0, gnt1}, 32'd0);
            tick();
        end
        res_ready = 1'b1;
        chk("stall_ready_no_gnt1", {31'd0, gnt1}, 32'd0);
        tick();
        chk("stall_valid_drop", {31'd0, res_valid}, 32'd0);
        chk("stall_gnt1_not_yet", {31'd0, gnt1}, 32'd0);
        tick();
        chk("stall_gnt1_after", {30'd0, gnt1, gnt0}, 32'd2);
        req1 = 1'b0;
        wait_idle();

        // Reset during EXEC: outputs clear at once and the next tie goes to requester 0.
        drive_req(1'b0, 3'd5, 8'h0F, 8'hF0);
        wait_gnt(ok);
        req0 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {20'd0, gnt0, gnt1, res, res_id, res_err, res_valid, busy},
            32'd0);
        sb.delete();
        tick();
        tick();
        chk("rst_mid_still_quiet", {30'd0, res_valid, busy}, 32'd0);
        rst_n = 1'b1;
        op0 = 3'd0; a0 = 8'hF0; b0 = 8'hCC;
        op1 = 3'd2; a1 = 8'h11; b1 = 8'h22;
        sb.push_back('{res: 8'hC0, id: 1'b0, err: 1'b0});
        req0 = 1'b1;
        req1 = 1'b1;
        wait_gnt(ok);
        if (ok) chk("rst_tie_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle();

`ifdef LOGIC_ARB_STATS_EN
        do_reset();
        res_ready = 1'b1;
        chk("cnt_reset", {16'd0, gnt_cnt0, gnt_cnt1}, 32'd0);
        for (int i = 0; i < 300; i++) begin
            av = 8'(i);
            run_op(1'b0, 3'd0, av, 8'hFF, av, 1'b0);
        end
        chk("cnt0_saturated", {24'd0, gnt_cnt0}, 32'd255);
        chk("cnt1_zero", {24'd0, gnt_cnt1}, 32'd0);
`endif

        tick();
        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
